// File: rtl/traffic_phase_ctrl_if.sv
// Control inputs and lamp/status outputs of the two-road phase controller.
// Width of the remaining-cycle counter follows the controller's CW.
interface traffic_phase_ctrl_if #(
    parameter int CW = 4
);
    logic          clr;
    logic          testl;
    logic          hold;
    logic          sens;
    logic [2:0]    main_lt;
    logic [2:0]    side_lt;
    logic [2:0]    phase;
    logic [CW-1:0] cnt;
    logic          tick;

    modport master (
        output clr, testl, hold, sens,
        input  main_lt, side_lt, phase, cnt, tick
    );

    modport slave (
        input  clr, testl, hold, sens,
        output main_lt, side_lt, phase, cnt, tick
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic-light phase sequencer driven by a per-phase down-counter,
// with side-road demand gating of main green, hold, clear and a one-cycle test mode.
//
// state | meaning
// ------+-------------------------------------------------
// S_MG  | main green, side red; leaves only with side demand
// S_MY  | main yellow, side red
// S_AR1 | all red after main road
// S_SG  | main red, side green
// S_SY  | main red, side yellow
// S_AR2 | all red after side road
module traffic_phase_ctrl #(
    parameter int CW         = 4,
    parameter int GREEN_MAIN = 10,
    parameter int GREEN_SIDE = 6,
    parameter int YELLOW     = 3,
    parameter int ALLRED     = 1
) (
    input  logic                ck,
    input  logic                resetn,
    traffic_phase_ctrl_if.slave bus
);
    localparam int DUR_MAX = 1 << CW;

    localparam bit PARAMS_OK =
        (CW >= 2) && (CW <= 16) &&
        (GREEN_MAIN >= 1) && (GREEN_MAIN <= DUR_MAX) &&
        (GREEN_SIDE >= 1) && (GREEN_SIDE <= DUR_MAX) &&
        (YELLOW     >= 1) && (YELLOW     <= DUR_MAX) &&
        (ALLRED     >= 1) && (ALLRED     <= DUR_MAX);

    generate
        if (!PARAMS_OK) begin : g_param_err
            $error("traffic_phase_ctrl: parameter out of range");
        end
        if ($bits(bus.cnt) != CW) begin : g_width_err
            $error("traffic_phase_ctrl: interface CW does not match module CW");
        end
    endgenerate

    localparam logic [CW-1:0] LD_MG = CW'(GREEN_MAIN - 1);
    localparam logic [CW-1:0] LD_SG = CW'(GREEN_SIDE - 1);
    localparam logic [CW-1:0] LD_YL = CW'(YELLOW - 1);
    localparam logic [CW-1:0] LD_AR = CW'(ALLRED - 1);

    typedef enum logic [2:0] {
        S_MG  = 3'd0,
        S_MY  = 3'd1,
        S_AR1 = 3'd2,
        S_SG  = 3'd3,
        S_SY  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          phase_end;

    // Test mode collapses every phase to a single cycle by loading zero.
    function automatic logic [CW-1:0] load_of(input state_t s, input logic testl);
        logic [CW-1:0] v;
        case (s)
            S_MG:        v = LD_MG;
            S_MY, S_SY:  v = LD_YL;
            S_SG:        v = LD_SG;
            default:     v = LD_AR;
        endcase
        return testl ? v : '0;
    endfunction

    function automatic state_t next_of(input state_t s);
        state_t n;
        case (s)
            S_MG:    n = S_MY;
            S_MY:    n = S_AR1;
            S_AR1:   n = S_SG;
            S_SG:    n = S_SY;
            S_SY:    n = S_AR2;
            default: n = S_MG;
        endcase
        return n;
    endfunction

    always_ff @(posedge ck) begin
        if (!resetn) begin
            state_q <= S_MG;
            cnt_q   <= LD_MG;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        phase_end = (cnt_q == '0) || !bus.testl;

        if (bus.clr) begin
            state_d = S_MG;
            cnt_d   = load_of(S_MG, bus.testl);
        end else if (!bus.hold) begin
            case (state_q)
                S_MG, S_MY, S_AR1, S_SG, S_SY, S_AR2: begin
                    // Main green is only released when the side road is asking for it.
                    if (phase_end && ((state_q != S_MG) || bus.sens)) begin
                        state_d = next_of(state_q);
                        cnt_d   = load_of(next_of(state_q), bus.testl);
                        tick_d  = 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = S_MG;
                    cnt_d   = load_of(S_MG, bus.testl);
                    tick_d  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        bus.main_lt = 3'b100;
        bus.side_lt = 3'b100;
        case (state_q)
            S_MG: begin
                bus.main_lt = 3'b001;
                bus.side_lt = 3'b100;
            end
            S_MY: begin
                bus.main_lt = 3'b010;
                bus.side_lt = 3'b100;
            end
            S_SG: begin
                bus.main_lt = 3'b100;
                bus.side_lt = 3'b001;
            end
            S_SY: begin
                bus.main_lt = 3'b100;
                bus.side_lt = 3'b010;
            end
            default: begin
                bus.main_lt = 3'b100;
                bus.side_lt = 3'b100;
            end
        endcase
    end

    assign bus.phase = state_q;
    assign bus.cnt   = cnt_q;
    assign bus.tick  = tick_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: vector table plus hand sequences checked through
// an expectation queue, and a second wide-counter instance for the long-green run.
module tb_traffic_phase_ctrl;
    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic resetn;
    logic resetn2;

    traffic_phase_ctrl_if #(.CW(4)) bus ();
    traffic_phase_ctrl_if #(.CW(6)) bus2 ();

    traffic_phase_ctrl #(.CW(4)) dut (
        .ck     (ck),
        .resetn (resetn),
        .bus    (bus)
    );

    traffic_phase_ctrl #(.CW(6), .GREEN_MAIN(40)) dut2 (
        .ck     (ck),
        .resetn (resetn2),
        .bus    (bus2)
    );

    typedef struct {
        logic [2:0]  ph;
        logic [15:0] cn;
        logic        tk;
        string       nm;
    } exp_t;

    typedef struct {
        logic  r, c, t, h, s;
        int    ph, cn;
        logic  tk;
        string nm;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[15];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   d1[6] = '{10, 3, 1, 6, 3, 1};
    int   d2[6] = '{40, 3, 1, 6, 3, 1};

    function automatic logic [5:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    // Position i cycles after reset in an uninterrupted run with demand always present.
    function automatic void exp_at(input int i, input int d[6],
                                   output int ph, output int cn, output logic tk);
        int pos;
        int tot;
        bit found;
        tot = 0;
        for (int p = 0; p < 6; p++) tot += d[p];
        pos = i % tot;
        ph = 0; cn = 0; tk = 1'b0; found = 1'b0;
        for (int p = 0; p < 6; p++) begin
            if (!found) begin
                if (pos < d[p]) begin
                    ph = p;
                    cn = d[p] - 1 - pos;
                    tk = (pos == 0) && (i != 0);
                    found = 1'b1;
                end else begin
                    pos -= d[p];
                end
            end
        end
    endfunction

    task automatic check_int(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic t, input logic h,
                        input logic s, input int ph, input int cn, input logic tk,
                        input string nm);
        exp_t e;
        @(negedge ck);
        resetn    = r;
        bus.clr   = c;
        bus.testl = t;
        bus.hold  = h;
        bus.sens  = s;
        e.ph = 3'(ph);
        e.cn = 16'(cn);
        e.tk = tk;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic run_mg(input string nm);
        for (int k = 8; k >= 0; k--) step(1, 0, 1, 0, 1, 0, k, 0, nm);
    endtask

    always @(posedge ck) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.phase !== e.ph || {12'b0, bus.cnt} !== e.cn || bus.tick !== e.tk ||
                {bus.main_lt, bus.side_lt} !== lamps_for(e.ph)) begin
                n_fail++;
                $display("FAIL %s: got phase=%0d cnt=%0d tick=%0b lamps=%b_%b, want phase=%0d cnt=%0d tick=%0b lamps=%b",
                         e.nm, bus.phase, bus.cnt, bus.tick, bus.main_lt, bus.side_lt,
                         e.ph, e.cn, e.tk, lamps_for(e.ph));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ph, cn, ticks, mg_len;
        logic tk;

        resetn     = 1'b0;
        resetn2    = 1'b0;
        bus.clr    = 1'b0;
        bus.testl  = 1'b1;
        bus.hold   = 1'b0;
        bus.sens   = 1'b1;
        bus2.clr   = 1'b0;
        bus2.testl = 1'b1;
        bus2.hold  = 1'b0;
        bus2.sens  = 1'b1;

        tbl[0]  = '{r:0, c:0, t:1, h:0, s:1, ph:0, cn:9, tk:0, nm:"reset"};
        tbl[1]  = '{r:1, c:0, t:0, h:0, s:1, ph:1, cn:0, tk:1, nm:"tm_mg"};
        tbl[2]  = '{r:1, c:0, t:0, h:0, s:1, ph:2, cn:0, tk:1, nm:"tm_my"};
        tbl[3]  = '{r:1, c:0, t:0, h:0, s:1, ph:3, cn:0, tk:1, nm:"tm_ar1"};
        tbl[4]  = '{r:1, c:0, t:0, h:0, s:1, ph:4, cn:0, tk:1, nm:"tm_sg"};
        tbl[5]  = '{r:1, c:0, t:0, h:0, s:1, ph:5, cn:0, tk:1, nm:"tm_sy"};
        tbl[6]  = '{r:1, c:0, t:0, h:0, s:1, ph:0, cn:0, tk:1, nm:"tm_wrap"};
        tbl[7]  = '{r:1, c:0, t:0, h:0, s:0, ph:0, cn:0, tk:0, nm:"tm_mg_nosens"};
        tbl[8]  = '{r:1, c:0, t:0, h:0, s:1, ph:1, cn:0, tk:1, nm:"tm_mg_sens"};
        tbl[9]  = '{r:0, c:0, t:0, h:0, s:1, ph:0, cn:9, tk:0, nm:"rst_tm"};
        tbl[10] = '{r:1, c:0, t:1, h:0, s:1, ph:0, cn:8, tk:0, nm:"mg_count"};
        tbl[11] = '{r:1, c:1, t:0, h:0, s:1, ph:0, cn:0, tk:0, nm:"clr_tm"};
        tbl[12] = '{r:1, c:1, t:1, h:0, s:1, ph:0, cn:9, tk:0, nm:"clr"};
        tbl[13] = '{r:1, c:0, t:1, h:1, s:1, ph:0, cn:9, tk:0, nm:"hold_mg"};
        tbl[14] = '{r:1, c:0, t:1, h:0, s:1, ph:0, cn:8, tk:0, nm:"hold_rel"};

        for (int i = 0; i < 15; i++)
            step(tbl[i].r, tbl[i].c, tbl[i].t, tbl[i].h, tbl[i].s,
                 tbl[i].ph, tbl[i].cn, tbl[i].tk, tbl[i].nm);

        // Two full cycles with demand always present.
        step(0, 0, 1, 0, 1, 0, 9, 0, "run_rst");
        ticks = 0;
        for (int i = 1; i <= 48; i++) begin
            exp_at(i, d1, ph, cn, tk);
            step(1, 0, 1, 0, 1, ph, cn, tk, "run24");
            @(posedge ck);
            #2;
            if (bus.tick === 1'b1) ticks++;
        end
        check_int("tick_count", ticks, 12);

        // No demand: MG parks at zero; early demand is ignored.
        step(0, 0, 1, 0, 1, 0, 9, 0, "sens_rst");
        for (int i = 1; i <= 30; i++)
            step(1, 0, 1, 0, (i <= 9) ? 1'($urandom_range(0, 1)) : 1'b0,
                 0, (9 - i > 0) ? 9 - i : 0, 0, "sens_low");
        step(1, 0, 1, 0, 1, 1, 2, 1, "sens_rise");

        // Test mode dropped in the middle of side green.
        step(1, 0, 1, 0, 1, 1, 1, 0, "my_1");
        step(1, 0, 1, 0, 1, 1, 0, 0, "my_0");
        step(1, 0, 1, 0, 1, 2, 0, 1, "ar1");
        step(1, 0, 1, 0, 1, 3, 5, 1, "sg_5");
        step(1, 0, 1, 0, 1, 3, 4, 0, "sg_4");
        step(1, 0, 0, 0, 1, 4, 0, 1, "testl_mid_sg");
        step(1, 0, 1, 0, 1, 5, 0, 1, "sy_after_tm");
        step(1, 0, 1, 0, 1, 0, 9, 1, "mg_after_tm");

        // Hold in side green, then clear together with hold in side yellow.
        run_mg("mg_run");
        step(1, 0, 1, 0, 1, 1, 2, 1, "my_2");
        step(1, 0, 1, 0, 1, 1, 1, 0, "my_1");
        step(1, 0, 1, 0, 1, 1, 0, 0, "my_0");
        step(1, 0, 1, 0, 1, 2, 0, 1, "ar1");
        step(1, 0, 1, 0, 1, 3, 5, 1, "sg_5");
        step(1, 0, 1, 0, 1, 3, 4, 0, "sg_4");
        step(1, 0, 1, 0, 1, 3, 3, 0, "sg_3");
        for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 1, 3, 3, 0, "hold_sg");
        step(1, 0, 1, 0, 1, 3, 2, 0, "hold_rel_2");
        step(1, 0, 1, 0, 1, 3, 1, 0, "hold_rel_1");
        step(1, 0, 1, 0, 1, 3, 0, 0, "hold_rel_0");
        step(1, 0, 1, 0, 1, 4, 2, 1, "sy_2");
        step(1, 0, 1, 1, 1, 4, 2, 0, "hold_sy_tick");
        step(1, 1, 1, 1, 1, 0, 9, 0, "clr_hold");

        // Reset while in the all-red clearance.
        run_mg("mg_run2");
        step(1, 0, 1, 0, 1, 1, 2, 1, "my_2b");
        step(1, 0, 1, 0, 1, 1, 1, 0, "my_1b");
        step(1, 0, 1, 0, 1, 1, 0, 0, "my_0b");
        step(1, 0, 1, 0, 1, 2, 0, 1, "ar1b");
        step(0, 0, 1, 0, 1, 0, 9, 0, "rst_ar1");
        step(1, 0, 1, 0, 1, 0, 8, 0, "after_rst");

        @(posedge ck);
        #3;
        check_int("queue_drained", sb.size(), 0);

        // Wide counter, long main green.
        @(negedge ck);
        resetn2 = 1'b0;
        @(posedge ck);
        #1;
        check_int("w_rst_phase", int'(bus2.phase), 0);
        check_int("w_rst_cnt", int'(bus2.cnt), 39);
        @(negedge ck);
        resetn2 = 1'b1;
        mg_len = 1;
        for (int i = 1; i <= 54; i++) begin
            @(posedge ck);
            #1;
            exp_at(i, d2, ph, cn, tk);
            n_tests++;
            if (int'(bus2.phase) != ph || int'(bus2.cnt) != cn || bus2.tick !== tk) begin
                n_fail++;
                $display("FAIL wide_run[%0d]: got phase=%0d cnt=%0d tick=%0b, want phase=%0d cnt=%0d tick=%0b",
                         i, bus2.phase, bus2.cnt, bus2.tick, ph, cn, tk);
            end
            if (i < 54 && bus2.phase == 3'd0) mg_len++;
        end
        check_int("wide_mg_len", mg_len, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
